sequence_player: RTL and testbench

Playback controller directly downstream of `sequence_rom` in the Simon game datapath. On a `start` pulse it walks ROM addresses 0..length-1, fetches each 2-bit colour through the ROM's registered read port, and lights the matching one-hot LED for a fixed on-time followed by a fixed gap. It reports `busy` while playing and pulses `done` when the last step has finished, so the game FSM can hand over to player input.

---
 rtl/simon_pkg.sv | 25 ++
 rtl/step_timer.sv | 33 +++
 rtl/sequence_player.sv | 178 +++++++++++++++++
 tb/tb_sequence_player.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and defaults for the Simon game datapath (sequence ROM, player, input checker).
package simon_pkg;

  typedef logic [1:0] color_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_ON    = 3'd3,
    ST_OFF   = 3'd4,
    ST_DONE  = 3'd5
  } player_state_t;

  // Default step timing at 50 MHz: 0.5 s lit, 0.25 s dark, ~500 Hz base tone.
  localparam int DEF_ON_CYCLES  = 25_000_000;
  localparam int DEF_OFF_CYCLES = 12_500_000;
  localparam int DEF_CNT_W      = 26;
  localparam int DEF_TONE_DIV   = 50_000;

  function automatic logic [3:0] onehot4(input color_t c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter; zero_o is high while the count sits at 0.
module step_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/sequence_player.sv
// Simon playback controller: walks sequence_rom and flashes one LED per step.
// Optional speaker tone is built when SEQUENCE_PLAYER_TONE_EN is defined.
module sequence_player
  import simon_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int OFF_CYCLES = DEF_OFF_CYCLES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int TONE_DIV   = DEF_TONE_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic [3:0]        led,
  output logic              tone,
  output logic              busy,
  output logic              done,
  output player_state_t     dbg_state_o,
  output color_t            dbg_color_o
);

  localparam int LEN_W = ADDR_W + 1;

  if (ON_CYCLES < 1 || OFF_CYCLES < 1 || TONE_DIV < 1) begin : g_param_check
    $error("sequence_player: ON_CYCLES, OFF_CYCLES and TONE_DIV must be >= 1");
  end

  player_state_t     state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, len_clamped;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [3:0]        led_q, led_d;
  color_t            color_q, color_d;
  logic              timer_load;
  logic [CNT_W-1:0]  timer_val;
  logic              timer_zero;

  assign len_clamped = (length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : length;

  step_timer #(.CNT_W(CNT_W)) u_step_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .zero_o     (timer_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    rd_addr_d  = rd_addr_q;
    led_d      = led_q;
    color_d    = color_q;
    timer_load = 1'b0;
    timer_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d = len_clamped;
          if (len_clamped == '0) begin
            state_d = ST_DONE;
          end else begin
            idx_d     = '0;
            rd_addr_d = '0;
            state_d   = ST_FETCH;
          end
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        // rd_data now reflects the address presented during FETCH.
        color_d    = rd_data;
        led_d      = onehot4(rd_data);
        timer_load = 1'b1;
        timer_val  = CNT_W'(ON_CYCLES - 1);
        state_d    = ST_ON;
      end
      ST_ON: begin
        if (timer_zero) begin
          led_d      = 4'b0000;
          timer_load = 1'b1;
          timer_val  = CNT_W'(OFF_CYCLES - 1);
          state_d    = ST_OFF;
        end
      end
      ST_OFF: begin
        if (timer_zero) begin
          if ({1'b0, idx_q} + LEN_W'(1) == len_q) begin
            state_d = ST_DONE;
          end else begin
            idx_d     = idx_q + ADDR_W'(1);
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            state_d   = ST_FETCH;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      idx_q     <= '0;
      rd_addr_q <= '0;
      led_q     <= 4'b0000;
      color_q   <= 2'b00;
    end else begin
      len_q     <= len_d;
      idx_q     <= idx_d;
      rd_addr_q <= rd_addr_d;
      led_q     <= led_d;
      color_q   <= color_d;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign led         = led_q;
  assign dbg_state_o = state_q;
  assign dbg_color_o = color_q;

`ifdef SEQUENCE_PLAYER_TONE_EN
  logic [31:0] div_q, div_d, half_period;
  logic        tone_q, tone_d;

  assign half_period = 32'(TONE_DIV) * (32'(color_q) + 32'd1);

  // Divider only runs while staying in ON, so it restarts from 0 on every ON entry.
  always_comb begin
    div_d  = '0;
    tone_d = 1'b0;
    if (state_q == ST_ON && state_d == ST_ON) begin
      if (div_q == half_period - 32'd1) begin
        div_d  = '0;
        tone_d = ~tone_q;
      end else begin
        div_d  = div_q + 32'd1;
        tone_d = tone_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;
`else
  assign tone = 1'b0;
`endif

endmodule

// File: tb/tb_sequence_player.sv
// Bench for sequence_player: ROM model, per-cycle trace reference, reset and ignore scenarios.
module tb_sequence_player;
  import simon_pkg::*;

  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 4;
  localparam int ON       = 4;
  localparam int OFF      = 2;
  localparam int CNT_W    = 4;
  localparam int TONE_DIV = 3;
  localparam int P        = 2 + ON + OFF;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   length;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_data = 2'b00;
  logic [3:0]        led;
  logic              tone;
  logic              busy;
  logic              done;
  player_state_t     dbg_state;
  color_t            dbg_color;

  logic [1:0] rom [16];
  int total = 0;
  int bad   = 0;
  int model_addr;
  // {led[3:0], busy, done, rd_addr[3:0]}
  logic [9:0] exp_q[$];

  sequence_player #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ON_CYCLES(ON), .OFF_CYCLES(OFF),
    .CNT_W(CNT_W), .TONE_DIV(TONE_DIV)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .length(length),
    .rd_addr(rd_addr), .rd_data(rd_data), .led(led), .tone(tone),
    .busy(busy), .done(done), .dbg_state_o(dbg_state), .dbg_color_o(dbg_color)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= rom[rd_addr];

  // Reference trace: cycle k after the start edge belongs to step (k-1)/P at phase (k-1)%P.
  task automatic build_exp(input int len_in);
    int n;
    logic [3:0] lv;
    n = (len_in > DEPTH) ? DEPTH : len_in;
    exp_q.delete();
    for (int k = 1; k <= n * P; k++) begin
      int s, ph;
      s  = (k - 1) / P;
      ph = (k - 1) % P;
      lv = (ph >= 2 && ph < 2 + ON) ? (4'b0001 << rom[s]) : 4'b0000;
      exp_q.push_back({lv, 1'b1, 1'b0, 4'(s)});
    end
    if (n > 0) model_addr = n - 1;
    exp_q.push_back({4'b0000, 1'b1, 1'b1, 4'(model_addr)});
    for (int i = 0; i < 3; i++) exp_q.push_back({4'b0000, 1'b0, 1'b0, 4'(model_addr)});
  endtask

  // Entered and left at #1 after a posedge.
  task automatic play(input int len_in, input int mid_k, input bit start_in_done, input string name);
    int n, done_k, k;
    logic [9:0] e, got;
    n      = (len_in > DEPTH) ? DEPTH : len_in;
    done_k = n * P + 1;
    build_exp(len_in);
    start  = 1'b1;
    length = 5'(len_in);
    @(posedge clk); #1;
    start = 1'b0;
    k = 1;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {led, busy, done, rd_addr};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s k=%0d got led=%b busy=%b done=%b addr=%0d expected led=%b busy=%b done=%b addr=%0d",
                 name, k, got[9:6], got[5], got[4], got[3:0], e[9:6], e[5], e[4], e[3:0]);
      end
      if (e[9:6] == 4'b0000) begin
        total++;
        if (tone !== 1'b0) begin
          bad++;
          $display("FAIL %s_tone k=%0d got tone=%b expected 0", name, k, tone);
        end
      end
      start  = (k == mid_k) || (start_in_done && k == done_k);
      length = 5'($urandom_range(0, 31));
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; length = '0;
    repeat (3) @(posedge clk);
    #1;
    total += 5;
    if (led !== 4'b0000)  begin bad++; $display("FAIL reset_led got %b expected 0000", led); end
    if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got %b expected 0", busy); end
    if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got %b expected 0", done); end
    if (rd_addr !== 4'd0) begin bad++; $display("FAIL reset_addr got %0d expected 0", rd_addr); end
    if (tone !== 1'b0)    begin bad++; $display("FAIL reset_tone got %b expected 0", tone); end
    rst = 1'b0;
    model_addr = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      total++;
      if ({led, busy, done, rd_addr} !== 10'b0) begin
        bad++;
        $display("FAIL idle cycle=%0d got led=%b busy=%b done=%b addr=%0d expected all 0",
                 i, led, busy, done, rd_addr);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_play();
    start = 1'b1; length = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (P + 3) @(posedge clk);
    #1;
    total++;
    if (led !== (4'b0001 << rom[1])) begin
      bad++; $display("FAIL rst_mid_pre_led got %b expected %b", led, 4'b0001 << rom[1]);
    end
    #2 rst = 1'b1;
    #1;
    total += 3;
    if (led !== 4'b0000) begin bad++; $display("FAIL rst_mid_led got %b expected 0000", led); end
    if (busy !== 1'b0)   begin bad++; $display("FAIL rst_mid_busy got %b expected 0", busy); end
    if (tone !== 1'b0)   begin bad++; $display("FAIL rst_mid_tone got %b expected 0", tone); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_addr = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL rst_mid_after cycle=%0d got done=%b busy=%b expected 0 0", i, done, busy);
      end
    end
    play(4, 0, 1'b0, "replay_after_rst");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int len, n, mid;
      for (int i = 0; i < DEPTH; i++) rom[i] = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 31);
      n   = (len > DEPTH) ? DEPTH : len;
      mid = (n > 0) ? $urandom_range(1, n * P) : 0;
      play(len, mid, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 2'(i % 4);
    test_reset();
    test_idle();
    play(4, 0, 1'b0, "len4");
    play(0, 0, 1'b0, "len0");
    play(31, 0, 1'b0, "clamp31");
    play(4, 10, 1'b1, "ignored_starts");
    play(3, 0, 1'b0, "third_start");
    play(0, 0, 1'b1, "len0_again");
    test_reset_mid_play();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
